ll_page_allocator: RTL and testbench

- Page-allocation manager at the responder end of the link-list page request/return/reclaim protocol.
- Sources pulse pgreq; the block acknowledges, pops a free page number from an internal circular free list, and returns it on lprq_* with srdy/drdy.
- Sinks hand freed pages back on lprt_*; those pages are pushed onto the free list.

---
 rtl/ll_page_allocator.sv | 145 ++++++++++++++
 tb/tb_ll_page_allocator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ll_page_allocator.sv
// Link-list page allocator: hands out free page numbers to requesting sources
// and takes freed pages back from sinks through a circular free-list RAM.
module ll_page_allocator #(
   parameter int lpsz    = 8,
   parameter int pages   = 256,
   parameter int sources = 4,
   parameter int sinks   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [sources-1:0]    pgreq,
   output logic [sources-1:0]    pgack,
   output logic [sources-1:0]    lprq_srdy,
   input  logic [sources-1:0]    lprq_drdy,
   output logic [lpsz-1:0]       lprq_page,
   input  logic [sinks-1:0]      lprt_srdy,
   output logic [sinks-1:0]      lprt_drdy,
   input  logic [sinks*lpsz-1:0] lprt_page_list,
   output logic [lpsz:0]         free_count
);

   // Handshakes: a word moves on a clock edge where srdy and drdy are both high
   // for the same lane; srdy and its data hold steady until that edge.
   localparam int sw = (sources > 1) ? $clog2(sources) : 1;
   localparam int kw = (sinks > 1) ? $clog2(sinks) : 1;
   localparam logic [lpsz:0]      full      = (lpsz+1)'(pages);
   localparam logic [lpsz:0]      full_m1   = (lpsz+1)'(pages - 1);
   localparam logic [lpsz-1:0]    last_addr = lpsz'(pages - 1);
   localparam logic [sources-1:0] src_one   = sources'(1);

   typedef enum logic {INIT, RUN} state_t;

   state_t             state;
   logic [lpsz-1:0]    mem [pages];
   logic [lpsz-1:0]    rd_ptr;
   logic [lpsz-1:0]    wr_ptr;
   logic [sources-1:0] pending;
   logic [sw-1:0]      src_ptr;
   logic [kw-1:0]      sink_ptr;

   logic               src_found;
   logic [sw-1:0]      src_sel;
   logic [sw-1:0]      src_idx;
   logic               sink_found;
   logic [kw-1:0]      sink_sel;
   logic [kw-1:0]      sink_idx;
   logic               alloc;
   logic               push;
   logic               take;
   logic [lpsz-1:0]    reclaim_page;
   logic               mem_we;
   logic [lpsz-1:0]    mem_wd;

   function automatic logic [lpsz-1:0] bump(input logic [lpsz-1:0] p);
      return (p == last_addr) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      src_found = 1'b0;
      src_sel   = '0;
      src_idx   = '0;
      for (int j = 0; j < sources; j++) begin
         src_idx = sw'((int'(src_ptr) + j) % sources);
         if (!src_found && pending[src_idx]) begin
            src_found = 1'b1;
            src_sel   = src_idx;
         end
      end
   end

   // Reclaim grant is combinational so a sink can transfer in the cycle it asks.
   always_comb begin
      sink_found = 1'b0;
      sink_sel   = '0;
      sink_idx   = '0;
      lprt_drdy  = '0;
      if (state == RUN && free_count < full) begin
         for (int j = 0; j < sinks; j++) begin
            sink_idx = kw'((int'(sink_ptr) + j) % sinks);
            if (!sink_found && lprt_srdy[sink_idx]) begin
               sink_found = 1'b1;
               sink_sel   = sink_idx;
            end
         end
      end
      if (sink_found) lprt_drdy[sink_sel] = 1'b1;
   end

   assign alloc        = (state == RUN) && (lprq_srdy == '0) && (free_count != '0) && src_found;
   assign push         = |(lprt_srdy & lprt_drdy);
   assign take         = |(lprq_srdy & lprq_drdy);
   assign reclaim_page = lprt_page_list[int'(sink_sel)*lpsz +: lpsz];
   assign mem_we       = (state == INIT) || push;
   assign mem_wd       = (state == INIT) ? wr_ptr : reclaim_page;

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr] <= mem_wd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         pgack      <= '0;
         lprq_srdy  <= '0;
         lprq_page  <= '0;
         free_count <= '0;
         pending    <= '0;
         src_ptr    <= '0;
         sink_ptr   <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         // A request from a source that already has one in flight is dropped.
         pgack   <= pgreq & ~pending;
         pending <= (pending | pgreq) & ~(lprq_srdy & lprq_drdy);
         case (state)
            INIT: begin
               wr_ptr     <= bump(wr_ptr);
               free_count <= free_count + 1'b1;
               if (free_count == full_m1) state <= RUN;
            end
            RUN: begin
               if (take) lprq_srdy <= '0;
               if (alloc) begin
                  lprq_srdy <= src_one << src_sel;
                  lprq_page <= mem[rd_ptr];
                  rd_ptr    <= bump(rd_ptr);
                  src_ptr   <= sw'((int'(src_sel) + 1) % sources);
               end
               if (push) begin
                  wr_ptr   <= bump(wr_ptr);
                  sink_ptr <= kw'((int'(sink_sel) + 1) % sinks);
               end
               case ({alloc, push})
                  2'b10:   free_count <= free_count - 1'b1;
                  2'b01:   free_count <= free_count + 1'b1;
                  default: free_count <= free_count;
               endcase
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_ll_page_allocator.sv
// Bench for ll_page_allocator: directed scenarios plus randomized traffic,
// scored against a free-list FIFO reference model.
module tb_ll_page_allocator;

   localparam int LPSZ  = 4;
   localparam int PAGES = 16;
   localparam int SRC   = 4;
   localparam int SNK   = 4;
   localparam int EW    = 4 + 4 + 4 + 4 + 5;

   logic              clk;
   logic              reset;
   logic [SRC-1:0]    pgreq;
   logic [SRC-1:0]    pgack;
   logic [SRC-1:0]    lprq_srdy;
   logic [SRC-1:0]    lprq_drdy;
   logic [LPSZ-1:0]   lprq_page;
   logic [SNK-1:0]    lprt_srdy;
   logic [SNK-1:0]    lprt_drdy;
   logic [SNK*LPSZ-1:0] lprt_page_list;
   logic [LPSZ:0]     free_count;

   ll_page_allocator #(.lpsz(LPSZ), .pages(PAGES), .sources(SRC), .sinks(SNK)) dut (
      .clk(clk), .reset(reset), .pgreq(pgreq), .pgack(pgack),
      .lprq_srdy(lprq_srdy), .lprq_drdy(lprq_drdy), .lprq_page(lprq_page),
      .lprt_srdy(lprt_srdy), .lprt_drdy(lprt_drdy), .lprt_page_list(lprt_page_list),
      .free_count(free_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   int             m_init;
   int             m_init_k;
   int             free_q[$];
   bit             m_pend[SRC];
   int             m_src_ptr;
   int             m_snk_ptr;
   int             m_out_src;
   int             m_page;
   logic [SRC-1:0] m_ack;

   logic [EW-1:0]  exp_q[$];
   logic [EW-1:0]  e;
   int             n_tests;
   int             n_fail;

   task automatic model_reset();
      m_init   = 1;
      m_init_k = 0;
      free_q.delete();
      for (int i = 0; i < SRC; i++) m_pend[i] = 0;
      m_src_ptr = 0;
      m_snk_ptr = 0;
      m_out_src = -1;
      m_page    = 0;
      m_ack     = '0;
   endtask

   // Predicts this cycle's outputs from the current inputs, then advances.
   task automatic model_step();
      logic [SNK-1:0] g;
      logic [SRC-1:0] srdy;
      logic [SRC-1:0] new_ack;
      int gk;
      int alloc;
      g  = '0;
      gk = -1;
      if (!m_init && free_q.size() < PAGES) begin
         for (int j = 0; j < SNK; j++) begin
            int k = (m_snk_ptr + j) % SNK;
            if (gk < 0 && lprt_srdy[k]) gk = k;
         end
      end
      if (gk >= 0) g[gk] = 1'b1;
      srdy = '0;
      if (m_out_src >= 0) srdy[m_out_src] = 1'b1;
      exp_q.push_back({m_ack, srdy, LPSZ'(m_page), g, (LPSZ+1)'(free_q.size())});
      if (reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < SRC; i++) new_ack[i] = pgreq[i] && !m_pend[i];
      alloc = -1;
      if (!m_init && m_out_src < 0 && free_q.size() > 0) begin
         for (int j = 0; j < SRC; j++) begin
            int i = (m_src_ptr + j) % SRC;
            if (alloc < 0 && m_pend[i]) alloc = i;
         end
      end
      if (m_out_src >= 0 && lprq_drdy[m_out_src]) begin
         m_pend[m_out_src] = 0;
         m_out_src = -1;
      end
      for (int i = 0; i < SRC; i++) if (new_ack[i]) m_pend[i] = 1;
      if (alloc >= 0) begin
         m_out_src = alloc;
         m_page    = free_q.pop_front();
         m_src_ptr = (alloc + 1) % SRC;
      end
      if (gk >= 0) begin
         free_q.push_back(int'(lprt_page_list[gk*LPSZ +: LPSZ]));
         m_snk_ptr = (gk + 1) % SNK;
      end
      if (m_init) begin
         free_q.push_back(m_init_k);
         m_init_k++;
         if (m_init_k == PAGES) m_init = 0;
      end
      m_ack = new_ack;
   endtask

   // driver
   task automatic drive(input logic r, input logic [SRC-1:0] rq, input logic [SRC-1:0] qd,
                        input logic [SNK-1:0] ts, input logic [SNK*LPSZ-1:0] pl);
      @(posedge clk);
      #1;
      reset          = r;
      pgreq          = rq;
      lprq_drdy      = qd;
      lprt_srdy      = ts;
      lprt_page_list = pl;
      model_step();
   endtask

   // scoreboard
   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pgack",      int'(pgack),      int'(e[20:17]));
         check("lprq_srdy",  int'(lprq_srdy),  int'(e[16:13]));
         check("lprq_page",  int'(lprq_page),  int'(e[12:9]));
         check("lprt_drdy",  int'(lprt_drdy),  int'(e[8:5]));
         check("free_count", int'(free_count), int'(e[4:0]));
      end
   end

   logic [SRC-1:0]      r_rq;
   logic [SRC-1:0]      r_qd;
   logic [SNK-1:0]      r_ts;
   logic [SNK*LPSZ-1:0] r_pl;
   logic                r_rst;
   int                  rq_pct;
   int                  rt_pct;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1; pgreq = '0; lprq_drdy = '0; lprt_srdy = '0; lprt_page_list = '0;
      model_reset();

      repeat (2) drive(1, '0, '0, '0, '0);
      // INIT with reclaim attempts that must not be granted
      for (int c = 0; c < 16; c++) drive(0, '0, '0, 4'($urandom_range(15)), 16'($urandom));
      drive(0, 4'b0001, 4'hf, '0, '0);
      repeat (5) drive(0, '0, 4'hf, '0, '0);
      drive(0, 4'hf, '0, '0, '0);
      repeat (3) drive(0, '0, '0, '0, '0);
      repeat (12) drive(0, '0, 4'hf, '0, '0);
      // drain the free list
      for (int c = 0; c < 50; c++) drive(0, 4'($urandom_range(15)), 4'hf, '0, '0);
      drive(0, 4'b0100, 4'hf, '0, '0);
      repeat (4) drive(0, '0, 4'hf, '0, '0);
      drive(0, '0, 4'hf, 4'b0100, 16'h0500);
      repeat (6) drive(0, '0, 4'hf, '0, '0);
      repeat (20) drive(0, '0, 4'hf, 4'hf, 16'hCBA9);
      // reset while a return is held
      drive(0, 4'b0010, '0, '0, '0);
      repeat (3) drive(0, '0, '0, '0, '0);
      drive(1, '0, '0, '0, '0);
      repeat (18) drive(0, '0, '0, '0, '0);

      for (int s = 0; s < 15; s++) begin
         rq_pct = $urandom_range(60, 5);
         rt_pct = $urandom_range(60, 5);
         for (int c = 0; c < 200; c++) begin
            for (int b = 0; b < SRC; b++) r_rq[b] = ($urandom_range(99) < rq_pct);
            for (int b = 0; b < SNK; b++) r_ts[b] = ($urandom_range(99) < rt_pct);
            r_qd  = 4'($urandom_range(15));
            r_pl  = 16'($urandom);
            r_rst = ($urandom_range(499) == 0);
            drive(r_rst, r_rq, r_qd, r_ts, r_pl);
         end
      end

      drive(0, '0, '0, '0, '0);
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
